// File: rtl/network_injector.sv
// NoC local-port source: packs AXI-Stream packets from the tile into header/body/tail flits
// and launches them into the router input under credit-based flow control.
module network_injector #(
  parameter int unsigned FLIT_DATA_WIDTH = 64,
  parameter int unsigned NODE_ID_WIDTH   = 4,
  parameter int unsigned LOCAL_NODE_ID   = 0,
  parameter int unsigned VN_WIDTH        = 2,
  parameter int unsigned CREDITS         = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [FLIT_DATA_WIDTH-1:0]         s_tdata_i,
  input  logic [NODE_ID_WIDTH-1:0]           s_tdest_i,
  input  logic [VN_WIDTH-1:0]                s_tid_i,
  input  logic                               s_tlast_i,
  input  logic                               s_tvalid_i,
  output logic                               s_tready_o,
  output logic [FLIT_DATA_WIDTH+1:0]         flit_o,
  output logic                               flit_valid_o,
  input  logic                               credit_i,
  output logic [$clog2(CREDITS+1)-1:0]       credits_o,
  output logic                               credit_overflow_o
);

  localparam int unsigned CreditW = $clog2(CREDITS + 1);
  localparam logic [1:0] TypeHead = 2'b00;
  localparam logic [1:0] TypeBody = 2'b01;
  localparam logic [1:0] TypeTail = 2'b10;

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

  state_e                     state_q, state_d;
  logic [FLIT_DATA_WIDTH+1:0] flit_q, flit_d;
  logic                       flit_valid_q;
  logic [CreditW-1:0]         credits_q, credits_d;
  logic                       overflow_q, overflow_d;
  logic                       launch;
  logic                       has_credit;
  logic [FLIT_DATA_WIDTH-1:0] header;

  assign has_credit = (credits_q != '0);

  // dest/vn are only consumed at header launch, so the header flit itself holds them
  always_comb begin
    header = '0;
    header[NODE_ID_WIDTH-1:0]                 = s_tdest_i;
    header[2*NODE_ID_WIDTH-1:NODE_ID_WIDTH]   = NODE_ID_WIDTH'(LOCAL_NODE_ID);
    header[2*NODE_ID_WIDTH+VN_WIDTH-1:2*NODE_ID_WIDTH] = s_tid_i;
  end

  always_comb begin
    state_d    = state_q;
    flit_d     = flit_q;
    launch     = 1'b0;
    s_tready_o = (state_q == StPayload) && has_credit;
    unique case (state_q)
      StIdle: begin
        if (s_tvalid_i && has_credit) begin
          launch  = 1'b1;
          flit_d  = {TypeHead, header};
          state_d = StPayload;
        end
      end
      StPayload: begin
        if (s_tvalid_i && s_tready_o) begin
          launch = 1'b1;
          if (s_tlast_i) begin
            flit_d  = {TypeTail, s_tdata_i};
            state_d = StIdle;
          end else begin
            flit_d  = {TypeBody, s_tdata_i};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A returned credit at a full counter is a router protocol error; count saturates
  always_comb begin
    credits_d  = credits_q;
    overflow_d = overflow_q;
    if (launch && !credit_i) begin
      credits_d = credits_q - CreditW'(1);
    end else if (!launch && credit_i) begin
      if (credits_q == CreditW'(CREDITS)) begin
        overflow_d = 1'b1;
      end else begin
        credits_d = credits_q + CreditW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credits_q    <= CreditW'(CREDITS);
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flit_q       <= flit_d;
      flit_valid_q <= launch;
      credits_q    <= credits_d;
      overflow_q   <= overflow_d;
    end
  end

  assign flit_o            = flit_q;
  assign flit_valid_o      = flit_valid_q;
  assign credits_o         = credits_q;
  assign credit_overflow_o = overflow_q;

endmodule
